// File: rtl/ber_sync_counter_pkg.sv
// Shared definitions for the BER sync counter: sweep state encoding,
// width helper and accumulator width.
package ber_sync_counter_pkg;

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;

  localparam int ACCUM_W = 64;

  // Counter width able to index n values; never narrower than one bit.
  function automatic int clog2_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ber_sync_counter_ref_delay_line.sv
// DEPTH-deep reference-bit shift register with a variable read tap.
// Tap 0 is the live input; tap k is the input from k enabled shifts ago.
module ber_sync_counter_ref_delay_line #(
  parameter int DEPTH = 511,
  parameter int SEL_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic [SEL_W-1:0] sel,
  output logic             dout
);

  logic [DEPTH-1:1]       stage_reg;
  logic [(1<<SEL_W)-1:0]  tap_vec;

  assign tap_vec[0]         = din;
  assign tap_vec[DEPTH-1:1] = stage_reg;

  generate
    if (DEPTH < (1 << SEL_W)) begin : g_pad
      // Unreachable tap codes read as zero.
      assign tap_vec[(1<<SEL_W)-1:DEPTH] = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg <= '0;
    end else if (en) begin
      stage_reg <= tap_vec[DEPTH-2:0];
    end
  end

  assign dout = tap_vec[sel];

endmodule

// File: rtl/ber_sync_counter.sv
// Per-rail bit-error counter: waits for equaliser convergence, sweeps every
// latency over one PRBS period each, then accumulates errors at the best one.
module ber_sync_counter
  import ber_sync_counter_pkg::*;
#(
  parameter int PRBS_MAX_CYCLES = 511,
  parameter int START_SYN       = 511*690,
  parameter int START_CNT       = START_SYN + 511*511,
  parameter int NBT_ACCUM       = ACCUM_W
) (
  input  logic                                  clk,
  input  logic                                  i_reset,
  input  logic                                  i_enable,
  input  logic                                  i_valid,
  input  logic                                  i_ref_bit,
  input  logic                                  i_rx_bit,
  output logic [clog2_w(PRBS_MAX_CYCLES)-1:0]   o_lat,
  output logic                                  o_locked,
  output logic [NBT_ACCUM-1:0]                  o_accum_err,
  output logic [NBT_ACCUM-1:0]                  o_accum_tot,
  output logic                                  o_ber_ok
);

  localparam int P       = PRBS_MAX_CYCLES;
  localparam int LAT_W   = clog2_w(P);
  localparam int SYM_W   = clog2_w(START_SYN + 1);
  localparam int ERR_W   = clog2_w(P + 1);
  // The sweep covers (START_CNT-START_SYN)/P windows, one per candidate latency.
  localparam int NUM_WIN = (START_CNT - START_SYN) / P;

  localparam logic [LAT_W-1:0] WIN_LAST  = LAT_W'(P - 1);
  localparam logic [LAT_W-1:0] CAND_LAST = LAT_W'(NUM_WIN - 1);
  localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(START_SYN - 1);

  logic [1:0]           state_reg,   state_next;
  logic [SYM_W-1:0]     sym_cnt_reg, sym_cnt_next;
  logic [LAT_W-1:0]     cand_reg,    cand_next;
  logic [LAT_W-1:0]     win_reg,     win_next;
  logic [ERR_W-1:0]     err_win_reg, err_win_next;
  logic [ERR_W-1:0]     min_err_reg, min_err_next;
  logic [LAT_W-1:0]     lat_next;
  logic                 locked_next;
  logic [NBT_ACCUM-1:0] err_next, tot_next;
  logic [ERR_W-1:0]     total;
  logic [LAT_W-1:0]     tap_sel;
  logic                 ref_tap;
  logic                 mismatch;
  logic                 sym_evt;

  assign sym_evt  = i_valid & i_enable;
  assign tap_sel  = (state_reg == ST_COUNT) ? o_lat : cand_reg;
  assign mismatch = i_rx_bit ^ ref_tap;

  ber_sync_counter_ref_delay_line #(
    .DEPTH (P),
    .SEL_W (LAT_W)
  ) u_ref_delay_line (
    .clk  (clk),
    .rst  (i_reset),
    .en   (sym_evt),
    .din  (i_ref_bit),
    .sel  (tap_sel),
    .dout (ref_tap)
  );

  always_comb begin
    state_next   = state_reg;
    sym_cnt_next = sym_cnt_reg;
    cand_next    = cand_reg;
    win_next     = win_reg;
    err_win_next = err_win_reg;
    min_err_next = min_err_reg;
    lat_next     = o_lat;
    locked_next  = o_locked;
    err_next     = o_accum_err;
    tot_next     = o_accum_tot;
    total        = err_win_reg + ERR_W'(mismatch);

    if (sym_evt) begin
      case (state_reg)
        ST_WAIT: begin
          sym_cnt_next = sym_cnt_reg + 1'b1;
          if (sym_cnt_reg == SYM_LAST) begin
            state_next   = ST_SYNC;
            cand_next    = '0;
            win_next     = '0;
            err_win_next = '0;
          end
        end
        ST_SYNC: begin
          if (win_reg == WIN_LAST) begin
            // Strict compare: on a tie the earlier (smaller) latency wins.
            if (total < min_err_reg) begin
              min_err_next = total;
              lat_next     = cand_reg;
            end
            win_next     = '0;
            err_win_next = '0;
            cand_next    = cand_reg + 1'b1;
            if (cand_reg == CAND_LAST) begin
              state_next  = ST_COUNT;
              locked_next = 1'b1;
            end
          end else begin
            err_win_next = total;
            win_next     = win_reg + 1'b1;
          end
        end
        ST_COUNT: begin
          if (o_accum_tot != '1) tot_next = o_accum_tot + 1'b1;
          if (mismatch && (o_accum_err != '1)) err_next = o_accum_err + 1'b1;
        end
        default: state_next = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg   <= ST_WAIT;
      sym_cnt_reg <= '0;
      cand_reg    <= '0;
      win_reg     <= '0;
      err_win_reg <= '0;
      min_err_reg <= '1;
      o_lat       <= '0;
      o_locked    <= 1'b0;
      o_accum_err <= '0;
      o_accum_tot <= '0;
      o_ber_ok    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sym_cnt_reg <= sym_cnt_next;
      cand_reg    <= cand_next;
      win_reg     <= win_next;
      err_win_reg <= err_win_next;
      min_err_reg <= min_err_next;
      o_lat       <= lat_next;
      o_locked    <= locked_next;
      o_accum_err <= err_next;
      o_accum_tot <= tot_next;
      o_ber_ok    <= locked_next & (err_next == '0);
    end
  end

endmodule

// File: tb/tb_ber_sync_counter.sv
// Scoreboard bench for ber_sync_counter with P=15, START_SYN=20, START_CNT=245
// and a PRBS4 reference; expectations are queued per event and checked by a monitor.
module tb_ber_sync_counter;

  localparam int P   = 15;
  localparam int SYN = 20;
  localparam int CNT = 245;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_enable = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ref_bit = 1'b0;
  logic        i_rx_bit = 1'b0;
  logic [3:0]  o_lat;
  logic        o_locked;
  logic [63:0] o_accum_err;
  logic [63:0] o_accum_tot;
  logic        o_ber_ok;

  ber_sync_counter #(
    .PRBS_MAX_CYCLES (P),
    .START_SYN       (SYN),
    .START_CNT       (CNT),
    .NBT_ACCUM       (64)
  ) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_valid     (i_valid),
    .i_ref_bit   (i_ref_bit),
    .i_rx_bit    (i_rx_bit),
    .o_lat       (o_lat),
    .o_locked    (o_locked),
    .o_accum_err (o_accum_err),
    .o_accum_tot (o_accum_tot),
    .o_ber_ok    (o_ber_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    bit          locked;
    bit          chk_lat;
    logic [3:0]  lat;
    logic [63:0] err;
    logic [63:0] tot;
    bit          ber_ok;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [3:0]  lfsr;
  logic [15:0] hist;
  int          evt_n;
  int          exp_err;

  task automatic check(input string nm, input int n, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s event=%0d got=%0d expected=%0d", nm, n, act, exp);
  endtask

  // Monitor: every accepted symbol is a transaction; compare after its edge.
  always begin
    @(posedge clk);
    if (!i_reset && i_valid && i_enable) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("unexpected_event", -1, 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("locked", mon_e.n, {63'd0, o_locked}, {63'd0, mon_e.locked});
        check("accum_err", mon_e.n, o_accum_err, mon_e.err);
        check("accum_tot", mon_e.n, o_accum_tot, mon_e.tot);
        check("ber_ok", mon_e.n, {63'd0, o_ber_ok}, {63'd0, mon_e.ber_ok});
        if (mon_e.chk_lat) check("lat", mon_e.n, {60'd0, o_lat}, {60'd0, mon_e.lat});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog event=%0d got=timeout expected=finish", evt_n);
    $fatal(1, "watchdog expired");
  end

  task automatic bench_clear();
    lfsr = 4'hF; hist = '0; evt_n = 0; exp_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_valid = 1'b0; i_enable = 1'b1; i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    bench_clear();
  endtask

  // One accepted symbol; rx is the reference delayed by dly events.
  task automatic issue_event(input int dly, input int gap, input bit invert);
    exp_t e;
    logic r, rx;
    r  = lfsr[3];
    rx = ((dly == 0) ? r : hist[dly-1]) ^ invert;
    lfsr = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    hist = {hist[14:0], r};
    evt_n++;
    if (invert && evt_n > CNT) exp_err++;
    e.n       = evt_n;
    e.locked  = (evt_n >= CNT);
    e.chk_lat = e.locked;
    e.lat     = 4'(dly);
    e.tot     = (evt_n > CNT) ? 64'(evt_n - CNT) : 64'd0;
    e.err     = 64'(exp_err);
    e.ber_ok  = e.locked && (exp_err == 0);
    exp_q.push_back(e);
    i_ref_bit = r; i_rx_bit = rx; i_valid = 1'b1;
    @(negedge clk);
    if (gap > 1) begin
      i_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic run_scenario(input string nm, input int dly, input int gap, input int n_evt,
                              input int inv_evt, input int freeze_evt);
    int fails_before;
    fails_before = n_checks - n_pass;
    for (int k = 1; k <= n_evt; k++) begin
      issue_event(dly, gap, k == inv_evt);
      if (k == freeze_evt) begin
        // Enable low while valid toggles with garbage data.
        i_enable = 1'b0;
        for (int c = 0; c < 50; c++) begin
          i_valid = ~i_valid;
          i_ref_bit = 1'($urandom);
          i_rx_bit = 1'($urandom);
          @(negedge clk);
        end
        i_valid = 1'b0; i_enable = 1'b1;
      end
    end
    i_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("queue_drained", evt_n, 64'(exp_q.size()), 64'd0);
    $display("scenario %s: events=%0d lat=%0d err=%0d tot=%0d new_failures=%0d",
             nm, evt_n, o_lat, o_accum_err, o_accum_tot, (n_checks - n_pass) - fails_before);
  endtask

  initial begin
    bench_clear();
    i_reset = 1'b1;
    #12;
    check("reset_lat", 0, {60'd0, o_lat}, 64'd0);
    check("reset_locked", 0, {63'd0, o_locked}, 64'd0);
    check("reset_err", 0, o_accum_err, 64'd0);
    check("reset_tot", 0, o_accum_tot, 64'd0);
    check("reset_ber_ok", 0, {63'd0, o_ber_ok}, 64'd0);
    @(negedge clk);
    i_reset = 1'b0;

    do_reset(); run_scenario("aligned_lock", 5, 4, CNT + 100, 0, 0);
    do_reset(); run_scenario("zero_latency", 0, 4, CNT + 15, 0, 0);
    do_reset(); run_scenario("single_error", 5, 4, CNT + 35, CNT + 15, 0);
    do_reset(); run_scenario("freeze", 5, 4, CNT + 15, 0, 100);

    do_reset(); run_scenario("pre_async_reset", 5, 4, CNT + 25, 0, 0);
    #2;
    i_reset = 1'b1;
    #1;
    check("async_rst_lat", evt_n, {60'd0, o_lat}, 64'd0);
    check("async_rst_locked", evt_n, {63'd0, o_locked}, 64'd0);
    check("async_rst_err", evt_n, o_accum_err, 64'd0);
    check("async_rst_tot", evt_n, o_accum_tot, 64'd0);
    check("async_rst_ber_ok", evt_n, {63'd0, o_ber_ok}, 64'd0);
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    bench_clear();
    run_scenario("resync_after_reset", 5, 4, CNT + 15, 0, 0);

    do_reset(); run_scenario("valid_every_clock", 5, 1, CNT + 100, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
